gmii_tx_framer: RTL and testbench
=================================

Name: gmii_tx_framer

Overview:
Transmit-side companion to the AGMII receive path, in the single agmii_clk domain. Takes raw AGMII frame bytes (data plus strobe, no preamble) from the packet engine and drives the GMII transmit pins. Buffers the frame in a small FIFO while it prepends the 7×0x55 preamble and 0xD5 SFD. Enforces the minimum inter-packet gap between frames. Reports FIFO overflow and underflow.

Parameters:
AW, 4, FIFO address width; depth 2^AW entries, 9 bits each ({last, data}).
PRE_LEN, 7, number of 0x55 preamble bytes before the SFD.
IFG, 12, minimum TX_EN-low cycles between frames.

Ports:
clk  input  1  agmii_clk, 125 MHz; all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
agmii_in  input  8  frame byte from the packet engine.
agmii_in_s  input  1  byte strobe; one contiguous high run is one frame.
TXD  output  8  GMII transmit data, registered.
TX_EN  output  1  GMII transmit enable, registered.
TX_ER  output  1  GMII transmit error, registered.
busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
overflow  output  1  sticky; set when a byte is dropped on a full FIFO.
underflow  output  1  sticky; set when the FIFO runs empty in DATA before a last-marked byte.
frame_count  output  16  frames completed on GMII; wraps modulo 2^16.

Behaviour:
- Reset (rst_n low, asynchronous): TXD=0, TX_EN=0, TX_ER=0, busy=0, overflow=0, underflow=0, frame_count=0. FIFO is emptied, FSM goes to IDLE, input register is cleared. Reset mid-frame truncates the frame immediately, with no TX_ER.
- Input stage:
  - agmii_in and agmii_in_s are registered once (d_r, s_r).
  - Next cycle, if s_r=1, write {last=!agmii_in_s, d_r} to the FIFO.
  - The final byte of each frame therefore carries last=1.
- Overflow: a write while the FIFO is full is dropped and overflow is set. A simultaneous read and write on a full FIFO is not an overflow.
- FSM states, with TX outputs registered from the state:
  - IDLE: TX_EN=0, TXD=0. If the FIFO is non-empty, go to PRE with the counter set to 0.
  - PRE: TX_EN=1, TXD=0x55 for PRE_LEN cycles, then go to SFD.
  - SFD: TX_EN=1, TXD=0xD5 for one cycle, then go to DATA.
  - DATA: pop one entry per cycle and drive TX_EN=1, TXD=data.
    - On an entry with last=1: go to GAP and increment frame_count.
    - If the FIFO is empty in DATA: drive TX_EN=1, TX_ER=1, TXD=0 for one cycle, set underflow, go to GAP; the remainder of that frame is then transmitted as a new frame.
  - GAP: TX_EN=0, TX_ER=0, TXD=0 for exactly IFG cycles, then go to IDLE. A pending FIFO entry starts PRE one cycle after that.
- Latency:
  - First strobed byte sampled at edge k → TX_EN rises at edge k+3.
  - First payload byte appears at edge k+3+PRE_LEN+1 (k+11 at defaults).
  - Constant per-byte pipeline; a contiguous input frame never underflows.
- Back-to-back frames: input frames spaced closer than IFG+PRE_LEN+1 cycles accumulate backlog in the FIFO. They are transmitted in order, with exactly IFG idle cycles between them, until the FIFO fills.
- TX_ER is 0 except in the underflow cycle.
- FIFO pointers wrap modulo 2^AW; full/empty is tracked with an (AW+1)-bit occupancy count.
- busy deasserts only in IDLE with the FIFO empty.

Test Plan:
- Single 64-byte frame (bytes 0x00..0x3F), strobe sampled first at edge 10:
  - Required: TX_EN high from edge 13 for 72 cycles.
  - TXD = 7×0x55, 0xD5, then 0x00..0x3F.
  - frame_count=1, overflow=0, underflow=0.
- Two 20-byte frames separated by a 1-cycle strobe gap:
  - Required: both transmitted intact, each with its own preamble and SFD.
  - TX_EN low for exactly 12 cycles between them.
  - frame_count=2, overflow=0.
- Minimum frame: a single 1-cycle strobe with byte 0xA5.
  - Required: TXD sequence 7×0x55, 0xD5, 0xA5 with TX_EN high for 9 cycles, then 12 cycles low.
  - busy low afterward.
- Continuous 1-byte frames, one every 2 cycles, for 100 cycles:
  - Required: overflow set within 40 cycles and stays high.
  - TX continues emitting well-formed 9-cycle frames with 12-cycle gaps.
- Assert rst_n low for 1 cycle midway through a 64-byte frame:
  - Required: TX_EN=0 and TXD=0 asynchronously; frame_count=0.
  - The next frame after reset is transmitted normally with full preamble.
- Force the FIFO empty in DATA (testbench drives last=0 on an internal write via a force, then stops):
  - Required: one cycle with TX_EN=1 and TX_ER=1, underflow=1, then a 12-cycle gap.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: buffers AGMII frame bytes in a small FIFO, prepends
// preamble and SFD, enforces the inter-packet gap, and flags FIFO faults.
module gmii_tx_framer #(
  parameter int unsigned AW      = 4,
  parameter int unsigned PRE_LEN = 7,
  parameter int unsigned IFG     = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  agmii_in,
  input  logic        agmii_in_s,
  output logic [7:0]  TXD,
  output logic        TX_EN,
  output logic        TX_ER,
  output logic        busy,
  output logic        overflow,
  output logic        underflow,
  output logic [15:0] frame_count
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StGap} state_t;

  logic [7:0]    d_r;
  logic          s_r;
  logic [8:0]    mem [DEPTH];
  logic [8:0]    wr_data;
  logic [8:0]    head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  state_t        state;
  logic [7:0]    cnt;

  // The byte in d_r is the last of its frame when the strobe has just dropped.
  assign wr_data = {~agmii_in_s, d_r};
  assign empty   = (count == '0);
  assign full    = count[AW];
  assign head    = mem[rd_ptr];
  assign rd_en   = (state == StData) && !empty;
  // A pop in the same cycle frees a slot, so a write on full still lands.
  assign wr_en   = s_r && (!full || rd_en);
  assign busy    = (state != StIdle) || !empty;

  // Input register stage for the engine byte and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r <= 8'h00;
      s_r <= 1'b0;
    end else begin
      d_r <= agmii_in;
      s_r <= agmii_in_s;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      if (s_r && full && !rd_en) overflow <= 1'b1;
    end
  end

  // Framing FSM; pin outputs are registered from the current state, so the
  // pins trail the state by one cycle. GAP holds IFG-1 state cycles because
  // the following IDLE cycle also drives TX_EN low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      cnt         <= 8'h00;
      TXD         <= 8'h00;
      TX_EN       <= 1'b0;
      TX_ER       <= 1'b0;
      underflow   <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      unique case (state)
        StIdle: begin
          TX_EN <= 1'b0;
          TX_ER <= 1'b0;
          TXD   <= 8'h00;
          if (!empty) begin
            state <= StPre;
            cnt   <= 8'h00;
          end
        end
        StPre: begin
          TX_EN <= 1'b1;
          TX_ER <= 1'b0;
          TXD   <= 8'h55;
          if (cnt == 8'(PRE_LEN - 1)) state <= StSfd;
          else                        cnt   <= cnt + 8'h01;
        end
        StSfd: begin
          TX_EN <= 1'b1;
          TX_ER <= 1'b0;
          TXD   <= 8'hD5;
          state <= StData;
        end
        StData: begin
          TX_EN <= 1'b1;
          cnt   <= 8'h00;
          if (!empty) begin
            TX_ER <= 1'b0;
            TXD   <= head[7:0];
            if (head[8]) begin
              state       <= StGap;
              frame_count <= frame_count + 16'h0001;
            end
          end else begin
            // Starved mid-frame: signal an error cycle and close the frame.
            TX_ER     <= 1'b1;
            TXD       <= 8'h00;
            underflow <= 1'b1;
            state     <= StGap;
          end
        end
        StGap: begin
          TX_EN <= 1'b0;
          TX_ER <= 1'b0;
          TXD   <= 8'h00;
          if (cnt == 8'(IFG - 2)) state <= StIdle;
          else                    cnt   <= cnt + 8'h01;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: scoreboard of expected GMII bytes checked on the
// falling clock edge, plus per-scenario checks of counters and flags.
module tb_gmii_tx_framer;

  localparam int IFG = 12;

  logic        clk;
  logic        rst_n;
  logic [7:0]  agmii_in;
  logic        agmii_in_s;

  logic [7:0]  txd0, txd1;
  logic        en0, en1, er0, er1, busy0, busy1, ovf0, ovf1, unf0, unf1;
  logic [15:0] fc0, fc1;

  // Second instance with a deeper FIFO: two 20-byte frames one cycle apart
  // need more than 16 entries of backlog while the first frame's gap runs.
  logic        sel;
  logic [7:0]  m_txd;
  logic        m_en, m_er, m_busy, m_ovf;
  logic [15:0] m_fc;

  assign m_txd  = sel ? txd1  : txd0;
  assign m_en   = sel ? en1   : en0;
  assign m_er   = sel ? er1   : er0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_ovf  = sel ? ovf1  : ovf0;
  assign m_fc   = sel ? fc1   : fc0;

  gmii_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .agmii_in(agmii_in), .agmii_in_s(agmii_in_s),
    .TXD(txd0), .TX_EN(en0), .TX_ER(er0), .busy(busy0), .overflow(ovf0),
    .underflow(unf0), .frame_count(fc0)
  );

  gmii_tx_framer #(.AW(5)) dut_deep (
    .clk(clk), .rst_n(rst_n), .agmii_in(agmii_in), .agmii_in_s(agmii_in_s),
    .TXD(txd1), .TX_EN(en1), .TX_ER(er1), .busy(busy1), .overflow(ovf1),
    .underflow(unf1), .frame_count(fc1)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", tag, got, want, cyc);
    end
  endtask

  // Scoreboard and monitor state.
  logic [8:0] exp_q[$];
  logic       mon_on = 1'b0;
  logic       pat_mode = 1'b0;
  logic       prev_en = 1'b0;
  logic       seen_frame = 1'b0;
  int         pos = 0;
  int         low_run = 0;
  int         hi_len = 0;
  int         rise_cyc = 0;
  int         gaps_seen = 0;
  int         mon_frames = 0;
  int         ov_cyc = -1;
  int         k_first = 0;

  // Monitor: compares every TX_EN-high cycle and measures gaps and lengths.
  always @(negedge clk) begin
    logic [8:0] want;
    if (mon_on) begin
      if (m_ovf && ov_cyc < 0) ov_cyc = cyc;
      if (m_en) begin
        if (!prev_en) begin
          if (seen_frame) begin
            check("ifg", 32'(low_run), 32'(IFG));
            gaps_seen++;
          end
          pos      = 0;
          rise_cyc = cyc;
        end
        if (pat_mode) begin
          want = (pos < 7) ? 9'h055 : (pos == 7) ? 9'h0D5 : 9'h077;
        end else if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
        end else begin
          want = 9'h1FF;  // nothing was expected on the wire
        end
        check("txd", 32'({m_er, m_txd}), 32'(want));
        pos++;
      end else begin
        if (prev_en) begin
          seen_frame = 1'b1;
          hi_len     = pos;
          mon_frames++;
          if (pat_mode) check("frame_len", 32'(pos), 32'd9);
          low_run = 0;
        end
        low_run++;
      end
      prev_en = m_en;
    end
  end

  task automatic clear_mon();
    exp_q.delete();
    prev_en    = 1'b0;
    seen_frame = 1'b0;
    pos        = 0;
    low_run    = 0;
    hi_len     = 0;
    gaps_seen  = 0;
    mon_frames = 0;
    ov_cyc     = -1;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    @(posedge clk); #1;
    rst_n      = 1'b0;
    agmii_in   = 8'h00;
    agmii_in_s = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    mon_on = 1'b1;
  endtask

  task automatic push_frame(input int n, input logic [7:0] base);
    for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, base + 8'(i)});
  endtask

  task automatic send_frame(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      agmii_in   = base + 8'(i);
      agmii_in_s = 1'b1;
      if (i == 0) k_first = cyc + 1;
    end
    @(posedge clk); #1;
    agmii_in_s = 1'b0;
    agmii_in   = 8'h00;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    repeat (4) @(posedge clk);
    #1;
    while ((m_busy || m_en) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", 32'(m_busy | m_en), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int kf;
    rst_n      = 1'b1;
    agmii_in   = 8'h00;
    agmii_in_s = 1'b0;
    sel        = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_txd",  32'(txd0),  32'd0);
    check("rst_en",   32'(en0),   32'd0);
    check("rst_er",   32'(er0),   32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_ovf",  32'(ovf0),  32'd0);
    check("rst_unf",  32'(unf0),  32'd0);
    check("rst_fc",   32'(fc0),   32'd0);

    // Single 64-byte frame.
    do_reset();
    push_frame(64, 8'h00);
    send_frame(64, 8'h00);
    kf = k_first;
    wait_idle(400);
    check("t1_rise_lat", 32'(rise_cyc - kf), 32'd3);
    check("t1_en_len",   32'(hi_len), 32'd72);
    check("t1_fc",       32'(m_fc), 32'd1);
    check("t1_ovf",      32'(m_ovf), 32'd0);
    check("t1_unf",      32'(unf0), 32'd0);
    check("t1_q_left",   32'(exp_q.size()), 32'd0);

    // Two 20-byte frames separated by one strobe-low cycle.
    do_reset();
    sel = 1'b1;
    push_frame(20, 8'h80);
    push_frame(20, 8'hC0);
    send_frame(20, 8'h80);
    send_frame(20, 8'hC0);
    wait_idle(600);
    check("t2_fc",     32'(m_fc), 32'd2);
    check("t2_ovf",    32'(m_ovf), 32'd0);
    check("t2_unf",    32'(unf1), 32'd0);
    check("t2_gaps",   32'(gaps_seen), 32'd1);
    check("t2_q_left", 32'(exp_q.size()), 32'd0);
    sel = 1'b0;

    // Minimum one-byte frame.
    do_reset();
    push_frame(1, 8'hA5);
    send_frame(1, 8'hA5);
    wait_idle(200);
    repeat (12) @(posedge clk);
    #1;
    check("t3_en_len",   32'(hi_len), 32'd9);
    check("t3_gap_low",  32'(low_run >= IFG), 32'd1);
    check("t3_busy",     32'(busy0), 32'd0);
    check("t3_fc",       32'(fc0), 32'd1);
    check("t3_q_left",   32'(exp_q.size()), 32'd0);

    // Flood of one-byte frames every two cycles.
    do_reset();
    pat_mode = 1'b1;
    kf = 0;
    for (int i = 0; i < 50; i++) begin
      send_frame(1, 8'h77);
      if (i == 0) kf = k_first;
    end
    check("t4_ovf_early", 32'(ov_cyc >= 0 && (ov_cyc - kf) <= 40), 32'd1);
    wait_idle(3000);
    check("t4_ovf_sticky", 32'(ovf0), 32'd1);
    check("t4_unf",        32'(unf0), 32'd0);
    check("t4_fc",         32'(fc0), 32'(mon_frames));
    check("t4_many",       32'(mon_frames >= 16), 32'd1);
    pat_mode = 1'b0;

    // Reset asserted mid-frame, then a fresh frame.
    do_reset();
    mon_on = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      agmii_in   = 8'(i);
      agmii_in_s = 1'b1;
    end
    check("t5_pre_en", 32'(en0), 32'd1);
    #1;
    rst_n      = 1'b0;
    agmii_in_s = 1'b0;
    #1;
    check("t5_async_en",  32'(en0), 32'd0);
    check("t5_async_txd", 32'(txd0), 32'd0);
    check("t5_async_fc",  32'(fc0), 32'd0);
    check("t5_async_er",  32'(er0), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    clear_mon();
    mon_on = 1'b1;
    push_frame(10, 8'h40);
    send_frame(10, 8'h40);
    kf = k_first;
    wait_idle(300);
    check("t5_rise_lat", 32'(rise_cyc - kf), 32'd3);
    check("t5_fc",       32'(fc0), 32'd1);
    check("t5_q_left",   32'(exp_q.size()), 32'd0);

    // Forced missing last marker starves DATA; a later frame tests the gap.
    do_reset();
    for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    exp_q.push_back(9'h03C);
    exp_q.push_back(9'h100);
    push_frame(1, 8'h5A);
    @(posedge clk); #1;
    agmii_in   = 8'h3C;
    agmii_in_s = 1'b1;
    @(posedge clk); #1;
    agmii_in_s = 1'b0;
    force dut.wr_data = 9'h03C;
    @(posedge clk); #1;
    release dut.wr_data;
    repeat (12) @(posedge clk);
    send_frame(1, 8'h5A);
    wait_idle(300);
    check("t6_unf",    32'(unf0), 32'd1);
    check("t6_fc",     32'(fc0), 32'd1);
    check("t6_gaps",   32'(gaps_seen), 32'd1);
    check("t6_ovf",    32'(ovf0), 32'd0);
    check("t6_q_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
